// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers a short program of 16-bit words and replays
// them on iin, holding each word for HOLD_CYCLES clocks, until the end of the
// buffer or a halt word is reached.
module instr_sequencer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [15:0] NOP_WORD    = 16'h0000,
    parameter logic [2:0]  HALT_OP     = 3'b111
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [15:0]              wr_data,
    output logic                     wr_ready,
    input  logic                     clear,
    input  logic                     start,
    output logic [15:0]              iin,
    output logic                     busy,
    output logic                     done_pulse,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   iin_q, iin_d;
    logic          err_q, err_d;
    logic          mem_we;
    logic [AW:0]   next_idx;
    logic [15:0]   next_word;
    logic [15:0]   first_word;

    logic [15:0] mem [DEPTH];

    // Program buffer: append at the current fill level; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[count_q[AW-1:0]] <= wr_data;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q <= StIdle;
            count_q <= '0;
            pc_q    <= '0;
            hold_q  <= '0;
            iin_q   <= NOP_WORD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            iin_q   <= iin_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: loading in idle, timed playback in run.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        iin_d      = iin_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        next_idx   = {1'b0, pc_q} + 1'b1;
        // Low bits only; when next_idx reaches DEPTH the n==count test ends the run first.
        next_word  = mem[next_idx[AW-1:0]];
        first_word = mem[0];

        unique case (state_q)
            StIdle: begin
                iin_d = NOP_WORD;
                if (start) begin
                    if (count_q == '0 || first_word[15:13] == HALT_OP) begin
                        state_d = StFin;
                    end else begin
                        state_d = StRun;
                        pc_d    = '0;
                        iin_d   = first_word;
                        hold_d  = HOLD_LOAD;
                    end
                end else if (clear) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (wr_en) begin
                    if (count_q < DEPTH_C) begin
                        mem_we  = 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (wr_en) begin
                    err_d = 1'b1;
                end
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (next_idx == count_q || next_word[15:13] == HALT_OP) begin
                    state_d = StFin;
                    iin_d   = NOP_WORD;
                end else begin
                    pc_d   = next_idx[AW-1:0];
                    iin_d  = next_word;
                    hold_d = HOLD_LOAD;
                end
            end
            StFin: begin
                iin_d   = NOP_WORD;
                state_d = StIdle;
                if (wr_en) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        wr_ready   = (state_q == StIdle) && (count_q < DEPTH_C);
        busy       = (state_q != StIdle);
        done_pulse = (state_q == StFin);
        iin        = iin_q;
        pc         = pc_q;
        count      = count_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with DEPTH=16, HOLD_CYCLES=4.
module tb_instr_sequencer;

    localparam int H = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        clear;
    logic        start;
    logic [15:0] iin;
    logic        busy;
    logic        done_pulse;
    logic [3:0]  pc;
    logic [4:0]  count;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_prog [16];

    instr_sequencer #(
        .DEPTH      (16),
        .HOLD_CYCLES(H),
        .NOP_WORD   (16'h0000),
        .HALT_OP    (3'b111)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clear     (clear),
        .start     (start),
        .iin       (iin),
        .busy      (busy),
        .done_pulse(done_pulse),
        .pc        (pc),
        .count     (count),
        .err       (err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Start and check every cycle of a run of nw issued words from exp_prog.
    task automatic play(input int nw, input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 1; s <= nw * H; s++) begin
            check({tag, " iin"}, 32'(iin), 32'(exp_prog[(s - 1) / H]));
            check({tag, " pc"}, 32'(pc), 32'((s - 1) / H));
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done early"}, 32'(done_pulse), 32'd0);
            tick();
        end
        check({tag, " done"}, 32'(done_pulse), 32'd1);
        check({tag, " fin busy"}, 32'(busy), 32'd1);
        check({tag, " fin iin"}, 32'(iin), 32'h0000);
        tick();
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(done_pulse), 32'd0);
        check({tag, " idle iin"}, 32'(iin), 32'h0000);
    endtask

    initial begin
        int s;
        resetn  = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        clear   = 1'b0;
        start   = 1'b0;

        // Reset
        tick();
        tick();
        resetn = 1'b0;
        check("rst iin", 32'(iin), 32'h0000);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst wr_ready", 32'(wr_ready), 32'd1);
        check("rst done", 32'(done_pulse), 32'd0);

        // Four-word program, then replay of the same buffer
        exp_prog[0] = 16'hA01C;
        exp_prog[1] = 16'hA40A;
        exp_prog[2] = 16'h2080;
        exp_prog[3] = 16'h8000;
        for (int i = 0; i < 4; i++) write_word(exp_prog[i]);
        check("prog4 count", 32'(count), 32'd4);
        play(4, "prog4");
        check("prog4 pc held", 32'(pc), 32'd3);
        play(4, "replay");

        // Halt word at index 1
        do_clear();
        write_word(16'hA01C);
        write_word(16'hE000);
        write_word(16'h2080);
        exp_prog[0] = 16'hA01C;
        play(1, "halt");

        // Priority: clear beats wr_en, start beats wr_en
        do_clear();
        write_word(16'h1234);
        check("prio count1", 32'(count), 32'd1);
        wr_en   = 1'b1;
        wr_data = 16'h5555;
        clear   = 1'b1;
        tick();
        wr_en   = 1'b0;
        clear   = 1'b0;
        check("prio clear count", 32'(count), 32'd0);
        check("prio clear err", 32'(err), 32'd0);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h1111;
        tick();
        start   = 1'b0;
        wr_en   = 1'b0;
        check("empty done", 32'(done_pulse), 32'd1);
        check("empty iin", 32'(iin), 32'h0000);
        check("empty count", 32'(count), 32'd0);
        check("empty err", 32'(err), 32'd0);
        tick();
        check("empty idle busy", 32'(busy), 32'd0);
        play(0, "empty");

        // Full buffer plus one dropped write
        for (int i = 0; i < 16; i++) begin
            exp_prog[i] = 16'h1000 + 16'(i);
            write_word(exp_prog[i]);
        end
        check("full wr_ready", 32'(wr_ready), 32'd0);
        check("full err pre", 32'(err), 32'd0);
        write_word(16'h7777);
        check("full count", 32'(count), 32'd16);
        check("full err", 32'(err), 32'd1);
        play(16, "full");
        check("full pc", 32'(pc), 32'd15);
        do_clear();
        check("clr count", 32'(count), 32'd0);
        check("clr err", 32'(err), 32'd0);
        check("clr wr_ready", 32'(wr_ready), 32'd1);

        // Writes and start during a run are dropped
        write_word(16'hA01C);
        write_word(16'hA40A);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busywr iin0", 32'(iin), 32'hA01C);
        wr_en   = 1'b1;
        wr_data = 16'hFFFF;
        start   = 1'b1;
        tick();
        wr_en   = 1'b0;
        start   = 1'b0;
        check("busywr count", 32'(count), 32'd2);
        check("busywr err", 32'(err), 32'd1);
        check("busywr iin", 32'(iin), 32'hA01C);
        s = 2;
        while (!done_pulse && s < 20) begin
            tick();
            s++;
        end
        check("busywr done cycle", 32'(s), 32'd9);
        tick();
        check("busywr idle", 32'(busy), 32'd0);
        do_clear();

        // Reset mid-run
        exp_prog[0] = 16'hA01C;
        exp_prog[1] = 16'hA40A;
        exp_prog[2] = 16'h2080;
        exp_prog[3] = 16'h8000;
        for (int i = 0; i < 4; i++) write_word(exp_prog[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 6; i++) tick();
        check("midrst iin t6", 32'(iin), 32'hA40A);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        check("midrst iin", 32'(iin), 32'h0000);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done_pulse), 32'd0);
        check("midrst count", 32'(count), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst no done", 32'(done_pulse), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
